// File: rtl/fir_mac_sched_pkg.sv
// Shared types and widths for the time-shared FIR MAC block.
// Also holds the helper that normalises the accumulator by the divisor.
package fir_mac_sched_pkg;

   localparam int SAMPLE_W = 4;
   localparam int PROD_W   = 8;
   localparam int ACC_W    = 11;
   localparam int ADDR_W   = 3;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic signed [PROD_W-1:0]   prod_t;
   typedef logic signed [ACC_W-1:0]    acc_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_e;

   // Signed division truncates toward zero; only the low sample bits are kept.
   function automatic sample_t norm_trunc(input acc_t acc, input int div);
      norm_trunc = SAMPLE_W'(int'(acc) / div);
   endfunction

endpackage

// File: rtl/fir_mac_sched_if.sv
// Sample, coefficient-write and result handshake bundle for fir_mac_sched.
// The master side is the surrounding system; the filter is the slave.
interface fir_mac_sched_if;
   import fir_mac_sched_pkg::*;

   logic              in_valid;
   logic              in_ready;
   sample_t           in_data;
   logic              coef_we;
   logic [ADDR_W-1:0] coef_addr;
   sample_t           coef_data;
   logic              out_valid;
   logic              out_ready;
   sample_t           out_data;
   logic              busy;

   modport master (
      output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );

endinterface

// File: rtl/booth_new.sv
// Combinational radix-2 Booth multiplier, 4x4 signed operands to 8-bit signed product.
module booth_new
   import fir_mac_sched_pkg::*;
(
   input  sample_t A,
   input  sample_t B,
   output prod_t   Z
);

   prod_t               a_ext;
   prod_t               sum;
   logic [SAMPLE_W:0]   b_ext;

   assign a_ext = PROD_W'(A);
   assign b_ext = {B, 1'b0};

   // Each adjacent bit pair {B[i], B[i-1]} selects +A, -A or nothing at weight 2^i.
   always_comb begin
      sum = '0;
      for (int i = 0; i < SAMPLE_W; i++) begin
         case (b_ext[i +: 2])
            2'b01:   sum = sum + (a_ext <<< i);
            2'b10:   sum = sum - (a_ext <<< i);
            default: ;
         endcase
      end
   end

   assign Z = sum;

endmodule

// File: rtl/fir_mac_sched.sv
// Time-shared FIR filter: one Booth multiplier walks the taps one per cycle,
// then the normalised result is held on a valid/ready output.
module fir_mac_sched
   import fir_mac_sched_pkg::*;
#(
   parameter int      NTAPS    = 5,
   parameter int      DIV      = 20,
   parameter sample_t COEF_RST = 4'sb0100
) (
   input logic            clk,
   input logic            rstn,
   fir_mac_sched_if.slave bus
);

   localparam int IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   acc_t             acc_q, acc_d;
   sample_t          f_q    [NTAPS];
   sample_t          f_d    [NTAPS];
   sample_t          coef_q [NTAPS];
   sample_t          coef_d [NTAPS];
   logic             out_valid_q, out_valid_d;
   sample_t          out_data_q, out_data_d;

   prod_t prod;
   logic  accept;
   logic  last_tap;
   logic  coef_wr;

   assign accept   = bus.in_valid && (state_q == IDLE);
   assign last_tap = (idx_q == IDX_W'(NTAPS - 1));
   assign coef_wr  = bus.coef_we && (state_q == IDLE) && (int'(bus.coef_addr) < NTAPS);

   booth_new u_mult (
      .A (f_q[idx_q]),
      .B (coef_q[idx_q]),
      .Z (prod)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_valid) state_d = MAC;
         MAC:     if (last_tap) state_d = OUT;
         OUT:     if (out_valid_q && bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready = (state_q == IDLE);
      bus.busy     = (state_q != IDLE);
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   // NOTE: every next-state signal starts from its hold value so no path
   // through this block leaves a variable unassigned (no latches).
   always_comb begin
      f_d         = f_q;
      coef_d      = coef_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      // The write lands at the same edge as acceptance, so MAC already sees it.
      if (coef_wr) coef_d[bus.coef_addr] = bus.coef_data;

      case (state_q)
         IDLE: begin
            if (accept) begin
               f_d[0] = bus.in_data;
               for (int k = 1; k < NTAPS; k++) f_d[k] = f_q[k-1];
               acc_d = '0;
               idx_d = '0;
            end
         end
         MAC: begin
            acc_d = acc_q + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
            idx_d = last_tap ? '0 : idx_q + 1'b1;
         end
         OUT: begin
            // The first OUT cycle registers the result; later ones wait for the consumer.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = norm_trunc(acc_q, DIV);
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // NOTE: the delay line and coefficient bank are reset explicitly because an
   // aborted operation must leave a known history and the default coefficients.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int k = 0; k < NTAPS; k++) begin
            f_q[k]    <= '0;
            coef_q[k] <= COEF_RST;
         end
      end else begin
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         f_q         <= f_d;
         coef_q      <= coef_d;
      end
   end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Bench for fir_mac_sched: two instances (DIV=20 and DIV=1) driven in lockstep
// and checked every cycle against a transaction-level model of the filter.
module tb_fir_mac_sched;

   localparam int NTAPS = 5;

   logic clk;
   logic rstn;

   fir_mac_sched_if bus ();
   fir_mac_sched_if bus1 ();

   assign bus1.in_valid  = bus.in_valid;
   assign bus1.in_data   = bus.in_data;
   assign bus1.coef_we   = bus.coef_we;
   assign bus1.coef_addr = bus.coef_addr;
   assign bus1.coef_data = bus.coef_data;
   assign bus1.out_ready = bus.out_ready;

   fir_mac_sched #(.NTAPS(NTAPS), .DIV(20), .COEF_RST(4'sb0100)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   fir_mac_sched #(.NTAPS(NTAPS), .DIV(1), .COEF_RST(4'sb0100)) dut_div1 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_f    [NTAPS];
   int m_coef [NTAPS];
   int m_acc;
   int m_exp20;
   int m_exp1;
   int m_cnt;
   bit m_pending;

   function automatic int sext4(input int v);
      logic signed [3:0] t;
      t = v[3:0];
      return int'(t);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NTAPS; k++) begin
         m_f[k]    = 0;
         m_coef[k] = 4;
      end
      m_pending = 1'b0;
      m_cnt     = 0;
   endtask

   // One clock edge of the filter seen as transactions: idle writes/accepts,
   // then NTAPS+1 edges of computation, then a held result until taken.
   task automatic model_step();
      if (m_pending) begin
         if (m_cnt >= NTAPS + 1 && bus.out_ready) m_pending = 1'b0;
         else m_cnt++;
      end else begin
         if (bus.coef_we && bus.coef_addr < NTAPS) m_coef[bus.coef_addr] = int'(bus.coef_data);
         if (bus.in_valid) begin
            for (int k = NTAPS - 1; k > 0; k--) m_f[k] = m_f[k-1];
            m_f[0] = int'(bus.in_data);
            m_acc = 0;
            for (int k = 0; k < NTAPS; k++) m_acc += m_f[k] * m_coef[k];
            m_exp20   = sext4(m_acc / 20);
            m_exp1    = sext4(m_acc);
            m_pending = 1'b1;
            m_cnt     = 0;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (rstn) model_step();
      end
   end

   initial begin
      forever begin
         @(negedge rstn);
         model_reset();
      end
   end

   // ---------------- per-cycle compare ----------------
   bit exp_valid;

   always @(negedge clk) begin
      exp_valid = m_pending && (m_cnt >= NTAPS + 1);
      check("in_ready", int'(bus.in_ready), int'(!m_pending));
      check("busy", int'(bus.busy), int'(m_pending));
      check("out_valid", int'(bus.out_valid), int'(exp_valid));
      check("out_valid_div1", int'(bus1.out_valid), int'(exp_valid));
      if (exp_valid) begin
         check("out_data", int'(bus.out_data), m_exp20);
         check("out_data_div1", int'(bus1.out_data), m_exp1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic wr_coef(input int a, input int d);
      @(negedge clk);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 3'(a);
      bus.coef_data = 4'(d);
      @(negedge clk);
      bus.coef_we = 1'b0;
   endtask

   task automatic send(input int s, input int hold, input bit wr_acc, input bit wr_hold,
                       input int wdata, output int got, output int got1);
      int t;
      int lat;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 4'(s);
      if (wr_acc) begin
         bus.coef_we   = 1'b1;
         bus.coef_addr = 3'd0;
         bus.coef_data = 4'(wdata);
      end
      t = 0;
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("accept_wait", int'(t < 50), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.coef_we  = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, NTAPS + 1);
      got  = int'(bus.out_data);
      got1 = int'(bus1.out_data);
      for (int i = 0; i < hold; i++) begin
         if (wr_hold && i == 0) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = 3'd0;
            bus.coef_data = 4'(wdata);
         end
         @(negedge clk);
         bus.coef_we = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish within 20000 cycles");
      $fatal(1);
   end

   int g, g1;

   initial begin
      rstn          = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.coef_we   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      bus.out_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_out_data", int'(bus.out_data), 0);
      check("reset_in_ready", int'(bus.in_ready), 1);
      rstn = 1'b1;

      // Single sample of 5 with all coefficients at 4.
      send(5, 0, 1'b0, 1'b0, 0, g, g1);
      check("s1_model_acc", m_acc, 20);
      check("s1_out", g, 1);
      check("s1_out_div1", g1, 4);

      // Five samples of 7.
      for (int n = 0; n < 5; n++) send(7, 0, 1'b0, 1'b0, 0, g, g1);
      check("s2_model_acc", m_acc, 140);
      check("s2_out", g, 7);

      // Five samples of -8, then a 1.
      for (int n = 0; n < 5; n++) send(-8, 0, 1'b0, 1'b0, 0, g, g1);
      check("s3_model_acc", m_acc, -160);
      check("s3_out", g, -8);
      send(1, 0, 1'b0, 1'b0, 0, g, g1);
      check("s3b_model_acc", m_acc, -124);
      check("s3b_out", g, -6);

      // Result held three cycles; a coefficient write during OUT must be ignored.
      send(2, 3, 1'b0, 1'b1, -7, g, g1);
      check("s4_out", g, -4);
      send(3, 0, 1'b0, 1'b0, 0, g, g1);
      check("s4_coef_unchanged", g, -2);

      // Single-tap filter of -1, then a write coinciding with acceptance.
      wr_coef(0, -1);
      for (int k = 1; k < NTAPS; k++) wr_coef(k, 0);
      wr_coef(5, 3);
      send(3, 0, 1'b0, 1'b0, 0, g, g1);
      check("s5_out", g, 0);
      check("s5_out_div1", g1, -3);
      send(4, 1, 1'b1, 1'b0, 2, g, g1);
      check("s5_same_cycle_write_div1", g1, -8);

      // Reset during the third MAC cycle.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 4'sd6;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1 rstn = 1'b0;
      @(negedge clk);
      check("s6_rst_in_ready", int'(bus.in_ready), 1);
      check("s6_rst_out_valid", int'(bus.out_valid), 0);
      #1 rstn = 1'b1;
      repeat (8) @(negedge clk);
      send(5, 0, 1'b0, 1'b0, 0, g, g1);
      check("s6_after_reset_out", g, 1);
      check("s6_after_reset_div1", g1, 4);

      // Randomised traffic against the model.
      for (int n = 0; n < 40; n++) begin
         int s, hold, wd;
         bit wa, wh;
         if ($urandom_range(0, 2) == 0)
            wr_coef(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)) - 8);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         s    = int'($urandom_range(0, 15)) - 8;
         hold = int'($urandom_range(0, 3));
         wa   = ($urandom_range(0, 1) == 1);
         wh   = ($urandom_range(0, 1) == 1);
         wd   = int'($urandom_range(0, 15)) - 8;
         send(s, hold, wa, wh, wd, g, g1);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_mac_sched.md
FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

Interface
REQ-001 Parameter NTAPS, default 5, meaning number of filter taps.
REQ-002 Parameter DIV, default 20, meaning the normalization divisor (5 taps x coefficient 4).
REQ-003 Parameter COEF_RST, default 4'sb0100, meaning the reset value of every coefficient.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1 bit: in_data holds a sample.
REQ-007 Port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-008 Port in_data, input, 4 bits: signed input sample.
REQ-009 Port coef_we, input, 1 bit: coefficient write strobe.
REQ-010 Port coef_addr, input, 3 bits: coefficient index.
REQ-011 Port coef_data, input, 4 bits: signed coefficient value.
REQ-012 Port out_valid, output, 1 bit: out_data holds a filtered result.
REQ-013 Port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-014 Port out_data, output, 4 bits: signed filtered result.
REQ-015 Port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-016 The block SHALL time-share one 4x4 signed multiplier across NTAPS taps, one product per cycle.
REQ-017 The FSM SHALL have three states: IDLE, MAC and OUT.
REQ-018 in_ready SHALL equal (state==IDLE).
REQ-019 On in_valid&&in_ready, the block SHALL shift the delay line (f[0]<=in_data, f[k]<=f[k-1]), clear acc, set tap index idx=0 and go to MAC.
REQ-020 In each MAC cycle, the block SHALL form the product f[idx]*coef[idx], add it sign-extended to acc, and increment idx.
REQ-021 The MAC state SHALL go to OUT in the cycle that processes idx==NTAPS-1.
REQ-022 The accumulator SHALL be 11-bit signed, so five 8-bit products never overflow.
REQ-023 On entry to OUT, out_data SHALL be registered as bits [3:0] of the signed quotient acc/DIV, truncated toward zero; out_valid SHALL be 1.
REQ-024 Latency: a sample accepted at edge T SHALL give out_valid=1 after edge T+NTAPS+1.
REQ-025 In OUT, out_valid and out_data SHALL hold stable until out_ready=1; the block then returns to IDLE with out_valid=0 at the next edge.
REQ-026 A new sample SHALL NOT be accepted in the cycle out_ready completes; the earliest acceptance is the following cycle.
REQ-027 A coefficient write SHALL take effect only when coef_we=1, state==IDLE and coef_addr<NTAPS; all other writes SHALL be ignored.
REQ-028 If coef_we and an input acceptance occur in the same IDLE cycle, the write SHALL complete first, so the new coefficient applies to that sample.

Reset
REQ-029 While rstn=0, the block SHALL force state=IDLE, idx=0, acc=0, all f[k]=0, all coef[k]=COEF_RST, out_valid=0 and out_data=0.
REQ-030 A reset asserted mid-MAC or mid-OUT SHALL abort the operation with no output produced.
REQ-031 After reset, in_ready SHALL be 1 in the first cycle.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the sample width (4), the product width (8) and the accumulator width (11).
REQ-033 The multiplier SHALL be exactly one instance of the existing radix-2 Booth sub-module booth_new, with A=f[idx], B=coef[idx] and Z feeding the accumulator.
REQ-034 The block SHALL contain no other multiplier and no "*" operator.

Verification
REQ-035 Scenario 1: after reset with all coefficients 4, send one sample of 5 -> acc=20, out_data=1 exactly NTAPS+1 cycles after acceptance.
REQ-036 Scenario 2: send five samples of 7 -> fifth result acc=140, out_data=7.
REQ-037 Scenario 3: send five samples of -8 -> acc=-160, out_data=4'b1000; then a sample of 1 gives acc=-124, out_data=-6 (4'b1010).
REQ-038 Scenario 4: hold out_ready=0 for 3 cycles in OUT -> out_data stable, in_ready=0, and a coef_we in that window is ignored (coefficient readback via the next result is unchanged).
REQ-039 Scenario 5: write coef[0]=-1 and coef[1..4]=0 in IDLE, then send 3 -> out_data=0 (-3/20 truncates to 0); set DIV=1 -> out_data=-3.
REQ-040 Scenario 6: pulse rstn low during the third MAC cycle -> no out_valid, delay line cleared, coefficients back to 4, in_ready=1 after release.
